radix4_dispatcher: RTL and testbench
====================================

// Module: radix4_dispatcher
// PURPOSE
//   Operand feeder and result collector for the radix-4 Booth multiplier (8x8 -> 16, unsigned).
//   Buffers x/y pairs in a FIFO and runs one multiplier job per pair.
//   Each job is: reset the multiplier, pulse start, hold operands, await ready.
//   The captured product is presented on a valid/ready output port.
// PARAMETERS
//   DEPTH    4   operand FIFO entries (power of 2, >=2)
//   AW       2   log2(DEPTH)
//   TIMEOUT  40  max WAIT cycles before error (used only with RADIX4_DISP_TIMEOUT_EN)
// PORTS
//   clock        in   1     sole clock, rising edge
//   reset_n      in   1     reset, active-low
//   in_valid     in   1     operand pair valid
//   in_ready     out  1     FIFO can accept; = reset_n && (count != DEPTH)
//   in_x         in   8     multiplicand
//   in_y         in   8     multiplier operand
//   mul_reset    out  1     active-high sync reset to multiplier
//   mul_start    out  1     start pulse to multiplier
//   mul_x        out  8     held operand x to multiplier
//   mul_y        out  8     held operand y to multiplier
//   mul_ready    in   1     multiplier done (sticky until mul_reset)
//   mul_product  in   16    multiplier result
//   out_valid    out  1     result valid
//   out_ready    in   1     consumer accepts result
//   out_product  out  16    result
//   out_err      out  1     result produced by timeout (qualified by out_valid)
//   busy         out  1     FSM not in IDLE
//   count        out  AW+1  FIFO occupancy
// BEHAVIOUR
//   Interface rules:
//     - One clock; reset is synchronous and active-low.
//     - reset_n=0 at any time, including mid-job, forces IDLE on the next edge.
//     - That edge empties the FIFO and clears count, out_valid, out_err, mul_start, out_product, mul_x and mul_y to 0.
//     - mul_reset=1 for every cycle that reset_n=0, so the multiplier is reset together with this block.
//   FIFO:
//     - Push when in_valid && in_ready. Pop only on the IDLE->CLEAR transition.
//     - Push and pop in the same cycle: count unchanged, data order preserved.
//     - Push when full is ignored even if a pop occurs in the same cycle, because in_ready depends only on count.
//     - Pointers wrap modulo DEPTH.
//   FSM (registered outputs):
//     - IDLE: go to CLEAR when count!=0 and out_valid=0. Load mul_x/mul_y from the FIFO head and pop.
//     - CLEAR: mul_reset=1 for exactly 1 cycle. Go to START.
//     - START: mul_start=1 for exactly 1 cycle. Go to WAIT.
//     - WAIT: when mul_ready=1, capture out_product<=mul_product and set out_valid=1. Go to OUT.
//     - OUT: hold out_valid, out_product and out_err stable until out_ready=1. On that edge clear out_valid and go to IDLE.
//   Operand and output rules:
//     - mul_x/mul_y stay constant from CLEAR through the end of WAIT; the multiplier samples them every cycle.
//     - out_valid and out_ready high in the same cycle = one transfer.
//     - Next job may enter CLEAR on the cycle after OUT exits; there is no overlap of jobs.
//   Latency:
//     - Pair accepted into an empty FIFO with the FSM idle: CLEAR begins 1 cycle later.
//     - out_valid rises 1 cycle after mul_ready is seen in WAIT.
//     - mul_ready is not sampled in CLEAR or START (stale sticky ready from the previous job is ignored).
//   Arithmetic: none in this block; out_product is passed through unmodified.
//   Idle outputs: mul_reset=0 and mul_start=0 outside CLEAR/START (except during reset).
//   busy=1 in CLEAR, START, WAIT and OUT.
// CONFIGURATION
//   RADIX4_DISP_TIMEOUT_EN defined:
//     - An 8-bit WAIT counter is cleared on entry to WAIT.
//     - If it reaches TIMEOUT without mul_ready, go to OUT with out_product=16'hFFFF and out_err=1.
//     - out_err clears when the result is transferred.
//   RADIX4_DISP_TIMEOUT_EN undefined: no counter; WAIT is unbounded; out_err is tied to 0.
// TESTING
//   T1: push (13,11) with out_ready=1, behavioural multiplier model
//       -> mul_reset 1 cycle, mul_start 1 cycle, then out_product=143 with out_valid for 1 cycle.
//   T2: push (255,255),(0,200),(1,1),(128,2) back-to-back with out_ready=1
//       -> results 65025, 0, 1, 256 in order; mul_x/mul_y stable throughout each WAIT.
//   T3: out_ready=0, push 6 pairs
//       -> in_ready drops after the 5th accept (4 in FIFO plus 1 in flight); count=4.
//       -> out_valid held with the first product stable; releasing out_ready drains all 5 results in order.
//   T4: reset_n=0 for 1 cycle mid-WAIT with 2 pairs queued
//       -> next cycle: count=0, busy=0, out_valid=0, mul_reset was 1 during the reset cycle.
//       -> no result emitted.
//   T5: simultaneous push and pop at count=DEPTH-1 -> count unchanged; FIFO order intact across pointer wrap.
//   T6 (TIMEOUT_EN): stub holds mul_ready=0, push (3,4)
//       -> after 40 WAIT cycles out_valid=1, out_product=16'hFFFF, out_err=1.
//       -> the next job still runs normally.

Source files
------------

// File: rtl/radix4_dispatcher.sv
// Operand FIFO and job sequencer for the radix-4 Booth multiplier (8x8 -> 16, unsigned).
// Optional RADIX4_DISP_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and flags the result with out_err.
module radix4_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic        mul_reset,
  output logic        mul_start,
  output logic [7:0]  mul_x,
  output logic [7:0]  mul_y,
  input  logic        mul_ready,
  input  logic [15:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        out_err,
  output logic        busy,
  output logic [AW:0] count
);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_e;

  // Elaboration guard: FIFO depth must match AW and the wait counter is 8 bits wide.
  if (DEPTH != (32'd1 << AW) || DEPTH < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("radix4_dispatcher: inconsistent DEPTH/AW/TIMEOUT");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [7:0]    mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic          mul_reset_q, mul_reset_d, mul_start_q, mul_start_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_product_q, out_product_d;
  logic          busy_q, busy_d;
`ifdef RADIX4_DISP_TIMEOUT_EN
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          out_err_q, out_err_d;
`endif

  assign in_ready = reset_n && (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_IDLE) && (count_q != '0) && !out_valid_q;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // Operand storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {in_x, in_y};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mul_x_q       <= '0;
      mul_y_q       <= '0;
      mul_reset_q   <= 1'b0;
      mul_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      busy_q        <= 1'b0;
`ifdef RADIX4_DISP_TIMEOUT_EN
      wait_cnt_q    <= '0;
      out_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mul_x_q       <= mul_x_d;
      mul_y_q       <= mul_y_d;
      mul_reset_q   <= mul_reset_d;
      mul_start_q   <= mul_start_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      busy_q        <= busy_d;
`ifdef RADIX4_DISP_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      out_err_q     <= out_err_d;
`endif
    end
  end

  // Job sequencing; strobes are registered by decoding the next state.
  always_comb begin
    state_d       = state_q;
    mul_x_d       = mul_x_q;
    mul_y_d       = mul_y_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
`ifdef RADIX4_DISP_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    out_err_d     = out_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d            = ST_CLEAR;
          {mul_x_d, mul_y_d} = fifo_q[rd_ptr_q];
        end
      end
      ST_CLEAR: state_d = ST_START;
      ST_START: begin
        state_d = ST_WAIT;
`ifdef RADIX4_DISP_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (mul_ready) begin
          state_d       = ST_OUT;
          out_valid_d   = 1'b1;
          out_product_d = mul_product;
        end
`ifdef RADIX4_DISP_TIMEOUT_EN
        else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d       = ST_OUT;
          out_valid_d   = 1'b1;
          out_product_d = 16'hFFFF;
          out_err_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
`ifdef RADIX4_DISP_TIMEOUT_EN
          out_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mul_reset_d = (state_d == ST_CLEAR);
    mul_start_d = (state_d == ST_START);
    busy_d      = (state_d != ST_IDLE);
  end

  // The multiplier is held in reset alongside this block.
  assign mul_reset   = mul_reset_q || !reset_n;
  assign mul_start   = mul_start_q;
  assign mul_x       = mul_x_q;
  assign mul_y       = mul_y_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign busy        = busy_q;
  assign count       = count_q;
`ifdef RADIX4_DISP_TIMEOUT_EN
  assign out_err     = out_err_q;
`else
  assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_radix4_dispatcher.sv
// Self-checking bench for radix4_dispatcher: behavioural multiplier stub, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_radix4_dispatcher;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y;
  logic        mul_reset, mul_start;
  logic [7:0]  mul_x, mul_y;
  logic        mul_ready;
  logic [15:0] mul_product;
  logic        out_valid, out_ready;
  logic [15:0] out_product;
  logic        out_err, busy;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  radix4_dispatcher dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .mul_reset(mul_reset), .mul_start(mul_start),
    .mul_x(mul_x), .mul_y(mul_y), .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_err(out_err), .busy(busy), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural multiplier: sticky ready, cleared only by mul_reset.
  logic        stub_ready = 1'b0;
  logic [15:0] stub_prod  = 16'd0;
  bit          stub_run   = 1'b0;
  bit          stub_hang  = 1'b0;
  int          stub_cnt   = 0;
  int          stub_lat   = 2;
  assign mul_ready   = stub_ready;
  assign mul_product = stub_prod;

  always @(posedge clock) begin
    if (mul_reset) begin
      stub_ready <= 1'b0;
      stub_run   <= 1'b0;
      stub_cnt   <= 0;
    end else if (mul_start) begin
      stub_run <= 1'b1;
      stub_cnt <= (stub_lat >= 0) ? stub_lat : int'($urandom_range(0, 6));
    end else if (stub_run && !stub_hang) begin
      if (stub_cnt == 0) begin
        stub_ready <= 1'b1;
        stub_prod  <= 16'(mul_x) * 16'(mul_y);
        stub_run   <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  bit rand_ready = 1'b0;
  always @(posedge clock) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: pending operand pairs, expected results in order, transfer log.
  logic [15:0] fifo_m [$];
  logic [15:0] exp_p [$];
  bit          exp_e [$];
  logic [15:0] got_log [$];
  bit          checking = 1'b0;
  bit          rst_pend = 1'b0, push_pend = 1'b0;
  logic [15:0] push_pair_m;
  bit          prev_hold = 1'b0, prev_job = 1'b0, prev_clear = 1'b0;
  logic [15:0] prev_prod, prev_ops;
  bit          prev_err;

  always @(negedge clock) begin
    logic [15:0] pr, ep;
    bit ee;
    if (rst_pend) begin
      fifo_m.delete(); exp_p.delete(); exp_e.delete();
    end else if (push_pend) begin
      fifo_m.push_back(push_pair_m);
    end
    if (checking) begin
      if (reset_n && mul_reset && !rst_pend) begin
        if (fifo_m.size() == 0) begin
          chk("job_without_operands", 32'(fifo_m.size()), 32'd1);
        end else begin
          pr = fifo_m.pop_front();
          chk("job_operands", 32'({mul_x, mul_y}), 32'(pr));
          exp_p.push_back(stub_hang ? 16'hFFFF : 16'(pr[15:8]) * 16'(pr[7:0]));
          exp_e.push_back(stub_hang);
        end
      end
      chk("count", 32'(count), 32'(fifo_m.size()));
      chk("in_ready", 32'(in_ready), 32'(reset_n && fifo_m.size() != 4));
      if (reset_n && out_valid && out_ready) begin
        if (exp_p.size() == 0) begin
          chk("unexpected_result", 32'(out_product), 32'hFFFF_FFFF);
        end else begin
          ep = exp_p.pop_front();
          ee = exp_e.pop_front();
          chk("out_product", 32'(out_product), 32'(ep));
          chk("out_err", 32'(out_err), 32'(ee));
          got_log.push_back(out_product);
        end
      end
      if (prev_hold && !rst_pend)
        chk("out_hold", 32'({out_valid, out_err, out_product}), 32'({1'b1, prev_err, prev_prod}));
      if (prev_job && !rst_pend && busy && !out_valid)
        chk("operand_stable", 32'({mul_x, mul_y}), 32'(prev_ops));
      if (reset_n && !rst_pend) begin
        chk("start_after_clear", 32'(mul_start), 32'(prev_clear));
        if (prev_clear) chk("clear_one_cycle", 32'(mul_reset), 32'd0);
      end
    end
    push_pend   = in_valid && in_ready;
    push_pair_m = {in_x, in_y};
    rst_pend    = !reset_n;
    prev_hold   = reset_n && out_valid && !out_ready;
    prev_prod   = out_product;
    prev_err    = out_err;
    prev_job    = reset_n && busy && !out_valid;
    prev_ops    = {mul_x, mul_y};
    prev_clear  = reset_n && mul_reset;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_pair(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    in_valid = 1'b1; in_x = x; in_y = y;
    do begin @(negedge clock); n++; end while (!in_ready && n < 200);
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_timeout: in_ready stuck low for pair %0d,%0d", x, y);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clock); n++; end
    while (!(busy == 1'b0 && count == 3'd0 && out_valid == 1'b0 && exp_p.size() == 0) && n < 400);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: not idle after %0d cycles (busy=%0d count=%0d)", name, n, busy, count);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_mul_reset", 32'(mul_reset), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_state", 32'({count, busy, out_valid, out_err, mul_start, mul_reset, in_ready}), 32'b000_0000001);
    chk("rst_data", 32'({mul_x, mul_y, out_product}), 32'd0);
    checking = 1'b1;
    @(posedge clock); #1;

    // T1: single job, CLEAR one cycle after accept
    push_pair(8'd13, 8'd11);
    @(negedge clock); chk("t1_idle_gap", 32'(mul_reset), 32'd0);
    @(negedge clock); chk("t1_clear", 32'(mul_reset), 32'd1);
    @(negedge clock); chk("t1_start", 32'(mul_start), 32'd1);
    @(posedge clock); #1;
    wait_idle("t1_idle");
    chk("t1_product", 32'(got_log[0]), 32'd143);

    // T2: back-to-back pushes with boundary operands
    base = got_log.size();
    push_pair(8'd255, 8'd255);
    push_pair(8'd0, 8'd200);
    push_pair(8'd1, 8'd1);
    push_pair(8'd128, 8'd2);
    wait_idle("t2_idle");
    chk("t2_r0", 32'(got_log[base]), 32'd65025);
    chk("t2_r1", 32'(got_log[base+1]), 32'd0);
    chk("t2_r2", 32'(got_log[base+2]), 32'd1);
    chk("t2_r3", 32'(got_log[base+3]), 32'd256);

    // T3: consumer stalled, FIFO fills behind one in-flight job
    base = got_log.size();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(8'(2 + 2*i), 8'(3 + 2*i));
    repeat (10) @(negedge clock);
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_first_held", 32'({out_valid, out_product}), 32'({1'b1, 16'd6}));
    @(posedge clock); #1;
    in_valid = 1'b1; in_x = 8'd12; in_y = 8'd13;
    repeat (3) @(negedge clock);
    chk("t3_blocked", 32'(count), 32'd4);
    @(posedge clock); #1;
    out_ready = 1'b1;
    push_pair(8'd12, 8'd13);
    wait_idle("t3_idle");
    chk("t3_r0", 32'(got_log[base]), 32'd6);
    chk("t3_r1", 32'(got_log[base+1]), 32'd20);
    chk("t3_r2", 32'(got_log[base+2]), 32'd42);
    chk("t3_r3", 32'(got_log[base+3]), 32'd72);
    chk("t3_r4", 32'(got_log[base+4]), 32'd110);
    chk("t3_r5", 32'(got_log[base+5]), 32'd156);

    // T4: reset mid-WAIT with two pairs queued
    stub_lat = 10;
    push_pair(8'd20, 8'd3);
    push_pair(8'd21, 8'd3);
    push_pair(8'd22, 8'd3);
    @(posedge clock); #1;
    base = got_log.size();
    reset_n = 1'b0;
    @(negedge clock);
    chk("t4_pre_count", 32'(count), 32'd2);
    chk("t4_mul_reset", 32'(mul_reset), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("t4_post", 32'({count, busy, out_valid}), 32'd0);
    repeat (20) @(negedge clock);
    chk("t4_no_result", 32'(got_log.size()), 32'(base));
    @(posedge clock); #1;

    // T5: push and pop on the same edge at count=DEPTH-1, pointers wrapped
    stub_lat = 1;
    base = got_log.size();
    out_ready = 1'b0;
    push_pair(8'd3, 8'd5);
    push_pair(8'd7, 8'd9);
    push_pair(8'd11, 8'd13);
    push_pair(8'd17, 8'd19);
    n = 0;
    do begin @(negedge clock); n++; end while (!out_valid && n < 50);
    chk("t5_queued", 32'({out_valid, count}), 32'({1'b1, 3'd3}));
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    push_pair(8'd23, 8'd29);
    @(negedge clock);
    chk("t5_count_same", 32'(count), 32'd3);
    chk("t5_popped", 32'(mul_reset), 32'd1);
    @(posedge clock); #1;
    wait_idle("t5_idle");
    chk("t5_r0", 32'(got_log[base]), 32'd15);
    chk("t5_r1", 32'(got_log[base+1]), 32'd63);
    chk("t5_r2", 32'(got_log[base+2]), 32'd143);
    chk("t5_r3", 32'(got_log[base+3]), 32'd323);
    chk("t5_r4", 32'(got_log[base+4]), 32'd667);

`ifdef RADIX4_DISP_TIMEOUT_EN
    // T6: multiplier never answers; timeout result, then a normal job
    base = got_log.size();
    stub_hang = 1'b1;
    push_pair(8'd3, 8'd4);
    n = 0;
    do begin @(negedge clock); n++; end while (!mul_start && n < 20);
    n = 0;
    do begin @(negedge clock); n++; end while (!out_valid && n < 100);
    chk("t6_wait_len", 32'(n), 32'd41);
    chk("t6_err_result", 32'({out_err, out_product}), 32'({1'b1, 16'hFFFF}));
    @(posedge clock); #1;
    stub_hang = 1'b0;
    push_pair(8'd5, 8'd6);
    wait_idle("t6_idle");
    chk("t6_r1", 32'(got_log[base+1]), 32'd30);
`endif

    // Randomized traffic with random consumer stalls and multiplier latency
    stub_lat  = -1;
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] rx, ry;
      rx = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
      ry = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      push_pair(rx, ry);
      for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
        @(posedge clock); #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clock); #2;
    out_ready = 1'b1;
    wait_idle("rand_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
